// File: rtl/or_test_pkg.sv
// Shared definitions for the OR exhaustive-stimulus block: default widths,
// hold-counter width, FSM state type and the err_cnt width derivation.
// No logic; imported by or_stim_gen and settle_timer.
package or_test_pkg;

    // Default pattern width and per-pattern settle cycles.
    localparam int DATA_W_DEF = 10;
    localparam int SETTLE_DEF = 2;

    // SETTLE ranges 0..15, so a 4-bit hold counter always suffices.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // err_cnt must reach 2^DATA_W without wrapping, hence one extra bit.
    function automatic int err_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Per-pattern hold counter: loads a settle value, counts down to zero.
// Latency: load/decrement take effect on the next clk edge; zero is registered-derived.
// Ports: clk, rst (sync, active-high), load, load_val, dec in; zero out. No backpressure.
module settle_timer
    import or_test_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Load wins over decrement; the counter never goes below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/or_stim_gen.sv
// Exhaustive stimulus generator: walks idata 0..all-ones, holds each pattern
// SETTLE+1 cycles, samples check on the last hold cycle and logs mismatches.
// Latency: done rises 2^DATA_W*(SETTLE+1) cycles after the edge accepting start.
// Ports: clk, rst, start, check in; idata, busy, done, err_cnt, err_flag, first_err out.
// No backpressure: start is ignored while busy.
module or_stim_gen
    import or_test_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int SETTLE = SETTLE_DEF,
    localparam int ERR_W  = err_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              check,
    output logic [DATA_W-1:0] idata,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err_flag,
    output logic [DATA_W-1:0] first_err
);

    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);
    // Largest possible count: every one of the 2^DATA_W patterns failed.
    localparam logic [ERR_W-1:0] ERR_MAX  = {1'b1, {DATA_W{1'b0}}};

    state_t            state_q;
    logic [DATA_W-1:0] idata_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [DATA_W-1:0] first_err_q;
    logic              busy_q;
    logic              done_q;

    logic tmr_zero;
    logic tmr_load;
    logic tmr_dec;
    logic start_ok;
    logic sample;
    logic last_pat;

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign sample   = (state_q == ST_HOLD) && tmr_zero;
    assign last_pat = &idata_q;

    // Reload on run start and whenever a sample moves to the next pattern.
    assign tmr_load = start_ok || (sample && !last_pat);
    assign tmr_dec  = (state_q == ST_HOLD) && !tmr_zero;

    settle_timer #(
        .CW (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (SETTLE_V),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idata_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q     <= ST_HOLD;
                        idata_q     <= '0;
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        if (!check) begin
                            if (err_cnt_q != ERR_MAX) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                            // Only the first mismatch of a run is recorded.
                            if (err_cnt_q == '0) begin
                                first_err_q <= idata_q;
                            end
                        end
                        if (last_pat) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idata_q <= idata_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign idata     = idata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cnt   = err_cnt_q;
    assign err_flag  = (err_cnt_q != '0);
    assign first_err = first_err_q;

endmodule

// File: tb/tb_or_stim_gen.sv
// Bench for or_stim_gen: a fault-injectable OR/checker pair drives check,
// runs are scored against a reference computed from the failing-pattern set,
// and a monitor compares each completed run against the queued expectation.
module tb_or_stim_gen;

    localparam int DW      = 10;
    localparam int ST      = 2;
    localparam int NPAT    = 1 << DW;
    localparam int RUN_CYC = NPAT * (ST + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          check;
    logic [DW-1:0] idata;
    logic          busy;
    logic          done;
    logic [DW:0]   err_cnt;
    logic          err_flag;
    logic [DW-1:0] first_err;

    always #5 clk = ~clk;

    or_stim_gen #(
        .DATA_W (DW),
        .SETTLE (ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .check     (check),
        .idata     (idata),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag),
        .first_err (first_err)
    );

    // OR under test plus checker: the OR output is compared with the ideal
    // reduction-OR; a set mask bit injects a fault on that pattern.
    bit   fail_mask [0:NPAT-1];
    logic or_out;
    assign or_out = (|idata) ^ fail_mask[idata];
    assign check  = (or_out == (|idata));

    typedef struct {
        int     errs;
        int     first;
        longint t_acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: a full run visits every pattern once, so the verdict is just
    // the number of faulty patterns and the lowest faulty one.
    function automatic exp_t model();
        exp_t e;
        e.errs  = 0;
        e.first = -1;
        e.t_acc = 0;
        for (int i = 0; i < NPAT; i++) begin
            if (fail_mask[i]) begin
                e.errs++;
                if (e.first < 0) e.first = i;
            end
        end
        if (e.first < 0) e.first = 0;
        return e;
    endfunction

    // Monitor: score every rising edge of done.
    bit done_prev = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no run pending");
                end else begin
                    e = exp_q.pop_front();
                    cmp("latency", 64'(($time - 5 - e.t_acc) / 10), 64'(RUN_CYC));
                    cmp("err_cnt", 64'(err_cnt), 64'(e.errs));
                    cmp("err_flag", 64'(err_flag), 64'(e.errs != 0));
                    cmp("first_err", 64'(first_err), 64'(e.first));
                    cmp("idata_final", 64'(idata), 64'(NPAT - 1));
                    cmp("busy_at_done", 64'(busy), 64'd0);
                end
            end
            done_prev = done;
        end
    end

    task automatic clear_mask();
        for (int i = 0; i < NPAT; i++) fail_mask[i] = 1'b0;
    endtask

    // Caller guarantees the DUT is in IDLE or DONE.
    task automatic do_start();
        exp_t e;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        e       = model();
        e.t_acc = $time;
        exp_q.push_back(e);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < RUN_CYC + 200; k++) begin
            @(negedge clk);
            if (done) break;
        end
        cmp(nm, 64'(done), 64'd1);
        @(negedge clk);
    endtask

    task automatic run_full(input string nm);
        do_start();
        wait_done(nm);
    endtask

    task automatic check_cleared(input string nm, input logic exp_busy);
        cmp({nm, "_idata"}, 64'(idata), 64'd0);
        cmp({nm, "_busy"}, 64'(busy), 64'(exp_busy));
        cmp({nm, "_done"}, 64'(done), 64'd0);
        cmp({nm, "_err_cnt"}, 64'(err_cnt), 64'd0);
        cmp({nm, "_err_flag"}, 64'(err_flag), 64'd0);
        cmp({nm, "_first_err"}, 64'(first_err), 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_mask();
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset", 1'b0);
        rst = 1'b0;

        // Ideal OR.
        run_full("ideal_timeout");

        // Single fault.
        clear_mask();
        fail_mask[10'h155] = 1'b1;
        run_full("one_fault_timeout");

        // Two faults; first one recorded.
        clear_mask();
        fail_mask[10'h003] = 1'b1;
        fail_mask[10'h200] = 1'b1;
        run_full("two_fault_timeout");

        // Checker stuck at mismatch: count saturates at 2^DW exactly.
        for (int i = 0; i < NPAT; i++) fail_mask[i] = 1'b1;
        run_full("stuck0_timeout");

        // Reset mid-run at idata=0x080.
        clear_mask();
        fail_mask[10'h010] = 1'b1;
        do_start();
        for (int k = 0; k < RUN_CYC; k++) begin
            @(negedge clk);
            if (idata == 10'h080) break;
        end
        cmp("reach_080", 64'(idata), 64'h080);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_cleared("midrun_rst", 1'b0);
        exp_q.delete();
        rst = 1'b0;
        clear_mask();
        run_full("after_rst_timeout");

        // Start pulses while busy must not disturb the run.
        clear_mask();
        fail_mask[$urandom_range(0, NPAT - 1)] = 1'b1;
        fail_mask[$urandom_range(0, NPAT - 1)] = 1'b1;
        do_start();
        repeat (3) begin
            repeat ($urandom_range(5, 800)) @(posedge clk);
            #1 start = 1'b1;
            cmp("busy_at_pulse", 64'(busy), 64'd1);
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done("ignore_start_timeout");

        // Restart from DONE with a non-zero verdict still displayed.
        clear_mask();
        fail_mask[10'h3FF] = 1'b1;
        do_start();
        check_cleared("restart", 1'b1);
        wait_done("restart_timeout");

        // Random fault sets.
        repeat (3) begin
            clear_mask();
            repeat ($urandom_range(0, 6)) fail_mask[$urandom_range(0, NPAT - 1)] = 1'b1;
            run_full("random_timeout");
        end

        repeat (2) @(negedge clk);
        cmp("pending_runs", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
